// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
package shift_add_multiplier_pkg;

  // Encoding 3 is never entered; the FSM maps it back to idle.
  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_RUN  = 2'd1,
    STATE_DONE = 2'd2
  } state_e;

  // Bit counter width: enough to hold 0..n-1, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/result handshake bundle for shift_add_multiplier.
// SHIFT_ADD_MULTIPLIER_SIGNED_EN adds the i_w_signed operand-mode signal.
interface shift_add_multiplier_if #(
  parameter int unsigned p_data_width = 8
);
  logic                        i_w_start;
  logic [p_data_width-1:0]     i_w_a;
  logic [p_data_width-1:0]     i_w_b;
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
  logic                        i_w_signed;
`endif
  logic                        o_w_busy;
  logic                        o_w_done;
  logic [2*p_data_width-1:0]   o_w_out;

  modport master (
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    output i_w_signed,
`endif
    output i_w_start, i_w_a, i_w_b,
    input  o_w_busy, o_w_done, o_w_out
  );

  modport slave (
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    input  i_w_signed,
`endif
    input  i_w_start, i_w_a, i_w_b,
    output o_w_busy, o_w_done, o_w_out
  );
endinterface

// File: rtl/shift_add_datapath.sv
// Datapath for the shift-and-add multiplier: operand shift registers, accumulator,
// one add/shift per step strobe, and the result register written on commit.
module shift_add_datapath #(
  parameter int unsigned p_data_width = 8
) (
  input  logic                      i_w_clk,
  input  logic                      i_w_reset,
  input  logic                      load,
  input  logic                      step,
  input  logic                      commit,
  input  logic [p_data_width-1:0]   a,
  input  logic [p_data_width-1:0]   b,
  input  logic                      signed_op,
  output logic [2*p_data_width-1:0] out
);
  localparam int unsigned N = p_data_width;

  logic [2*N-1:0] mcand_q;
  logic [N-1:0]   mplier_q;
  logic [2*N-1:0] acc_q;
  logic           sign_q;
  logic [2*N-1:0] out_q;

  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [2*N-1:0] acc_next;

  // Magnitudes of the operands; the most negative value maps to 2^(N-1) unsigned.
  always_comb begin
    a_mag = (signed_op && a[N-1]) ? (~a + 1'b1) : a;
    b_mag = (signed_op && b[N-1]) ? (~b + 1'b1) : b;
    acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // Operand capture, per-bit add/shift, and the result write on the final step.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      if (load) begin
        mcand_q  <= {{N{1'b0}}, a_mag};
        mplier_q <= b_mag;
        acc_q    <= '0;
        sign_q   <= signed_op & (a[N-1] ^ b[N-1]);
      end else if (step) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
      // Commit coincides with the last step, so it must see that step's add.
      if (commit) begin
        out_q <= sign_q ? (~acc_next + 1'b1) : acc_next;
      end
    end
  end

  assign out = out_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle shift-and-add multiplier: one multiplier bit per clock, N+1 edges
// from accepted start to result. SHIFT_ADD_MULTIPLIER_SIGNED_EN enables
// two's-complement operands selected per operation by i_w_signed.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned p_data_width = 8
) (
  input logic                  i_w_clk,
  input logic                  i_w_reset,
  shift_add_multiplier_if.slave bus
);
  localparam int unsigned CntWidth = cnt_width(p_data_width);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(p_data_width - 1);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  load, step, commit;
  logic                  signed_op;

`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
  assign signed_op = bus.i_w_signed;
`else
  assign signed_op = 1'b0;
`endif

  // State and bit counter registers.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state_q <= STATE_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and datapath strobes; start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      STATE_IDLE, STATE_DONE: begin
        if (bus.i_w_start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = STATE_RUN;
        end
      end
      STATE_RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          commit  = 1'b1;
          state_d = STATE_DONE;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  assign bus.o_w_busy = (state_q == STATE_RUN);
  assign bus.o_w_done = (state_q == STATE_DONE);

  shift_add_datapath #(
    .p_data_width(p_data_width)
  ) u_datapath (
    .i_w_clk   (i_w_clk),
    .i_w_reset (i_w_reset),
    .load      (load),
    .step      (step),
    .commit    (commit),
    .a         (bus.i_w_a),
    .b         (bus.i_w_b),
    .signed_op (signed_op),
    .out       (bus.o_w_out)
  );

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (N=8): directed vectors push their
// hand-computed products; a monitor compares on each rising edge of o_w_done.
module tb_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_add_multiplier_if #(.p_data_width(8)) bus ();

  shift_add_multiplier #(.p_data_width(8)) dut (
    .i_w_clk   (clk),
    .i_w_reset (rst),
    .bus       (bus)
  );

  logic [15:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic        done_prev = 1'b0;
  logic [15:0] last_out = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: a new result is presented when o_w_done rises.
  always @(negedge clk) begin
    if (bus.o_w_done && !done_prev) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got out=%0d expected no result", bus.o_w_out);
      end else begin
        check("product", {16'd0, bus.o_w_out}, {16'd0, exp_q.pop_front()});
      end
    end
    done_prev = bus.o_w_done;
  end

  task automatic set_signed(input logic sgn);
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    bus.i_w_signed = sgn;
`else
    if (sgn) $display("note: signed request ignored in unsigned build");
`endif
  endtask

  // Called #1 after the accepting edge; walks the run, checking the busy window
  // and that the old product is held until the final edge.
  task automatic wait_result(input logic [15:0] hold, input bit scramble, input int pulse_at);
    int busy_cycles = 0;
    for (int k = 0; k < 20 && !bus.o_w_done; k++) begin
      if (bus.o_w_busy) busy_cycles++;
      check("hold_out", {16'd0, bus.o_w_out}, {16'd0, hold});
      if (scramble) begin
        bus.i_w_a = 8'($urandom);
        bus.i_w_b = 8'($urandom);
      end
      if (k == pulse_at) begin
        bus.i_w_start = 1'b1;
        bus.i_w_a     = 8'd100;
        bus.i_w_b     = 8'd100;
      end else begin
        bus.i_w_start = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.i_w_start = 1'b0;
    check("done_seen", {31'd0, bus.o_w_done}, 32'd1);
    check("busy_cycles", busy_cycles, 32'd8);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                        input logic [15:0] expv, input bit scramble, input int pulse_at);
    exp_q.push_back(expv);
    bus.i_w_a     = a;
    bus.i_w_b     = b;
    set_signed(sgn);
    bus.i_w_start = 1'b1;
    @(posedge clk); #1;
    bus.i_w_start = 1'b0;
    check("busy_after_start", {31'd0, bus.o_w_busy}, 32'd1);
    check("done_after_start", {31'd0, bus.o_w_done}, 32'd0);
    wait_result(last_out, scramble, pulse_at);
    last_out = expv;
  endtask

  initial begin
    bus.i_w_start = 1'b1;   // start during reset must be dropped
    bus.i_w_a     = 8'd1;
    bus.i_w_b     = 8'd1;
    set_signed(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, bus.o_w_busy}, 32'd0);
    check("reset_done", {31'd0, bus.o_w_done}, 32'd0);
    check("reset_out", {16'd0, bus.o_w_out}, 32'd0);
    bus.i_w_start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", {31'd0, bus.o_w_busy}, 32'd0);

    run_op(8'd13, 8'd11, 1'b0, 16'd143, 1'b0, -1);
    run_op(8'd255, 8'd255, 1'b0, 16'hFE01, 1'b0, -1);
    run_op(8'd0, 8'd200, 1'b0, 16'd0, 1'b0, -1);
    run_op(8'd200, 8'd0, 1'b0, 16'd0, 1'b0, -1);

    // Start pulse at cycle 4 of a run is ignored.
    run_op(8'd7, 8'd9, 1'b0, 16'd63, 1'b0, 3);
    @(posedge clk); #1;
    check("stay_done", {31'd0, bus.o_w_done}, 32'd1);
    check("done_out_63", {16'd0, bus.o_w_out}, 32'd63);
    run_op(8'd100, 8'd100, 1'b0, 16'd10000, 1'b0, -1);

    // Reset at cycle 5 of a run aborts it.
    bus.i_w_a     = 8'd9;
    bus.i_w_b     = 8'd9;
    bus.i_w_start = 1'b1;
    @(posedge clk); #1;
    bus.i_w_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_run_busy", {31'd0, bus.o_w_busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.o_w_busy}, 32'd0);
    check("abort_done", {31'd0, bus.o_w_done}, 32'd0);
    check("abort_out", {16'd0, bus.o_w_out}, 32'd0);
    last_out = 16'd0;
    @(posedge clk); #1;
    check("abort_idle", {31'd0, bus.o_w_busy}, 32'd0);
    run_op(8'd3, 8'd4, 1'b0, 16'd12, 1'b0, -1);

    // Operands changing after capture do not disturb the run.
    run_op(8'd5, 8'd6, 1'b0, 16'd30, 1'b1, -1);

`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    run_op(8'hFD, 8'd5, 1'b1, 16'hFFF1, 1'b0, -1);
    run_op(8'h80, 8'h80, 1'b1, 16'd16384, 1'b0, -1);
    run_op(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b0, -1);
`endif
    run_op(8'hFD, 8'd5, 1'b0, 16'd1265, 1'b0, -1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
